// File: rtl/aes_decipher_block.sv
`default_nettype none
// ============================================================================
// aes_decipher_block -- iterative AES decryption, one round per clock
// (Nr = 10/12/14); S-box and round keys are supplied externally.
// Optional macro AES_DEC_ROUND_CHECK_EN: reject starts with unsupported Nr.
// Revision: 1.0
// ============================================================================
module aes_decipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [3:0]   aes_round,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  inv_sboxw0,
    output logic [31:0]  inv_sboxw1,
    output logic [31:0]  inv_sboxw2,
    output logic [31:0]  inv_sboxw3,
    input  logic [31:0]  new_inv_sboxw0,
    input  logic [31:0]  new_inv_sboxw1,
    input  logic [31:0]  new_inv_sboxw2,
    input  logic [31:0]  new_inv_sboxw3,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_MAIN  = 2'd2,
        ST_FINAL = 2'd3
    } fsm_t;

    fsm_t         fsm_state, fsm_nxt;
    logic [127:0] data_state, data_nxt;
    logic [3:0]   round_nxt;
    logic [3:0]   num_rounds, num_rounds_nxt;
    logic         ready_nxt;
    logic         error_nxt;
    logic         round_ok;
    logic [127:0] sboxed;
    logic [127:0] shifted_key;
    logic [127:0] mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8, acc;
        b2  = xt(b);
        b4  = xt(b2);
        b8  = xt(b4);
        acc = 8'h00;
        if (k[0]) acc = acc ^ b;
        if (k[1]) acc = acc ^ b2;
        if (k[2]) acc = acc ^ b4;
        if (k[3]) acc = acc ^ b8;
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // Byte (row r, column c) sits at index 4*c+r, byte 0 being the MSB.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

`ifdef AES_DEC_ROUND_CHECK_EN
    assign round_ok = (aes_round == 4'd10) || (aes_round == 4'd12) || (aes_round == 4'd14);
`else
    assign round_ok = 1'b1;
`endif

    assign inv_sboxw0 = data_state[127:96];
    assign inv_sboxw1 = data_state[95:64];
    assign inv_sboxw2 = data_state[63:32];
    assign inv_sboxw3 = data_state[31:0];
    assign new_block  = data_state;

    assign sboxed      = {new_inv_sboxw0, new_inv_sboxw1, new_inv_sboxw2, new_inv_sboxw3};
    assign shifted_key = inv_shift_rows(sboxed) ^ round_key;
    assign mixed       = {inv_mix_word(shifted_key[127:96]), inv_mix_word(shifted_key[95:64]),
                          inv_mix_word(shifted_key[63:32]),  inv_mix_word(shifted_key[31:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state  <= ST_IDLE;
            data_state <= '0;
            round      <= 4'd0;
            num_rounds <= 4'd0;
            ready      <= 1'b1;
            error      <= 1'b0;
        end else begin
            fsm_state  <= fsm_nxt;
            data_state <= data_nxt;
            round      <= round_nxt;
            num_rounds <= num_rounds_nxt;
            ready      <= ready_nxt;
            error      <= error_nxt;
        end
    end

    // Counter decrements saturate at 0 so an unsupported Nr still terminates quickly.
    always_comb begin
        fsm_nxt        = fsm_state;
        data_nxt       = data_state;
        round_nxt      = round;
        num_rounds_nxt = num_rounds;
        ready_nxt      = ready;
        error_nxt      = 1'b0;
        case (fsm_state)
            ST_IDLE: begin
                if (next) begin
                    if (round_ok) begin
                        data_nxt       = block;
                        num_rounds_nxt = aes_round;
                        round_nxt      = aes_round;
                        ready_nxt      = 1'b0;
                        fsm_nxt        = ST_INIT;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                data_nxt  = data_state ^ round_key;
                round_nxt = (num_rounds == 4'd0) ? 4'd0 : num_rounds - 4'd1;
                fsm_nxt   = ST_MAIN;
            end
            ST_MAIN: begin
                data_nxt  = mixed;
                round_nxt = (round == 4'd0) ? 4'd0 : round - 4'd1;
                if (round <= 4'd1) fsm_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                data_nxt  = shifted_key;
                round_nxt = 4'd0;
                ready_nxt = 1'b1;
                fsm_nxt   = ST_IDLE;
            end
            default: fsm_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire
